// File: rtl/mantisa_normalizer_seq.sv
// Multi-cycle mantissa normalizer: scans the magnitude one slice per cycle from the MSB,
// then left-shifts to put the leading 1 at bit WIDTH-1 and adjusts the exponent.
module mantisa_normalizer_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8,
  parameter int unsigned EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mag,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mag,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_zero,
  output logic             out_uflow
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned SHW    = $clog2(WIDTH);
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned ENCW   = (SLICE > 1) ? $clog2(SLICE) : 1;
  // Common width for the unsigned exponent-vs-shift comparison.
  localparam int unsigned CW     = ((EXP_W > SHW) ? EXP_W : SHW) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StShift,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [SHW-1:0]    pos_q, pos_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_mag_q, out_mag_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic              out_zero_q, out_zero_d;
  logic              out_uflow_q, out_uflow_d;

  logic [SLICE-1:0]  slice;
  logic [ENCW-1:0]   enc;
  logic [SHW-1:0]    sh;
  logic              no_uflow;
  logic [WIDTH-1:0]  mag_norm;
  logic [WIDTH-1:0]  mag_denorm;
  logic [EXP_W-1:0]  exp_norm;

  // Slice under examination and its leading-1 position.
  always_comb begin
    slice = mag_q[idx_q*SLICE +: SLICE];
    enc   = '0;
    for (int i = 0; i < int'(SLICE); i++) begin
      if (slice[i]) begin
        enc = i[ENCW-1:0];
      end
    end
  end

  always_comb begin
    sh         = SHW'(WIDTH - 1) - pos_q;
    no_uflow   = CW'(exp_q) >= CW'(sh);
    mag_norm   = mag_q << sh;
    // Shift only as far as the exponent allows; result is denormal.
    mag_denorm = mag_q << exp_q;
    exp_norm   = exp_q - EXP_W'(sh);
  end

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    idx_d       = idx_q;
    pos_d       = pos_q;
    out_valid_d = out_valid_q;
    out_mag_d   = out_mag_q;
    out_exp_d   = out_exp_q;
    out_zero_d  = out_zero_q;
    out_uflow_d = out_uflow_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mag_d   = in_mag;
          exp_d   = in_exp;
          idx_d   = IDXW'(NSLICE - 1);
          state_d = StScan;
        end
      end
      StScan: begin
        if (|slice) begin
          pos_d   = SHW'(idx_q * SLICE) + SHW'(enc);
          state_d = StShift;
        end else if (idx_q != '0) begin
          idx_d = idx_q - IDXW'(1);
        end else begin
          out_mag_d   = '0;
          out_exp_d   = '0;
          out_zero_d  = 1'b1;
          out_uflow_d = 1'b0;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StShift: begin
        if (no_uflow) begin
          out_mag_d   = mag_norm;
          out_exp_d   = exp_norm;
          out_uflow_d = 1'b0;
        end else begin
          out_mag_d   = mag_denorm;
          out_exp_d   = '0;
          out_uflow_d = 1'b1;
        end
        out_zero_d  = 1'b0;
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mag_q       <= '0;
      exp_q       <= '0;
      idx_q       <= '0;
      pos_q       <= '0;
      out_valid_q <= 1'b0;
      out_mag_q   <= '0;
      out_exp_q   <= '0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      idx_q       <= idx_d;
      pos_q       <= pos_d;
      out_valid_q <= out_valid_d;
      out_mag_q   <= out_mag_d;
      out_exp_q   <= out_exp_d;
      out_zero_q  <= out_zero_d;
      out_uflow_q <= out_uflow_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = out_valid_q;
  assign out_mag   = out_mag_q;
  assign out_exp   = out_exp_q;
  assign out_zero  = out_zero_q;
  assign out_uflow = out_uflow_q;

endmodule
